// File: rtl/ps2_key_controller.sv
// PS/2 set-2 scancode decoder: arrow-key held state and direction, Space pause toggle, Esc pulse.
// Optional macro PS2_WASD_EN also maps W/S/A/D onto the up/down/left/right directions.
module ps2_key_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ack,
  output logic [3:0] key_held,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       pause,
  output logic       esc_pulse
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StConsume, StWaitLow} state_e;

  state_e          state_q, state_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      arrow_q, arrow_d, held_d;
  logic [1:0]      dir_q, dir_d;
  logic            pause_q, pause_d, esc_q, esc_d;
  logic            consume, key_hit;
  logic [1:0]      key_idx;
`ifdef PS2_WASD_EN
  logic [3:0]      wasd_q, wasd_d;
  logic            key_wasd;
`endif

  // Lowest set bit wins: up > down > left > right.
  function automatic logic [1:0] first_held(input logic [3:0] h);
    logic [1:0] idx;
    if (h[0])      idx = 2'd0;
    else if (h[1]) idx = 2'd1;
    else if (h[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (data_valid) state_d = StConsume;
      StConsume: state_d = StWaitLow;
      StWaitLow: if (!data_valid) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ack = (state_q == StConsume);
  end

  assign consume = (state_q == StConsume);

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    cnt_d   = cnt_q;
    arrow_d = arrow_q;
    dir_d   = dir_q;
    pause_d = pause_q;
    esc_d   = 1'b0;
    key_hit = 1'b0;
    key_idx = 2'd0;
`ifdef PS2_WASD_EN
    wasd_d   = wasd_q;
    key_wasd = 1'b0;
`endif
    if (consume) begin
      cnt_d = '0;
      if (data_in == 8'hE0) begin
        ext_d = 1'b1;
      end else if (data_in == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q) begin
          case (data_in)
            8'h75:   begin key_hit = 1'b1; key_idx = 2'd0; end
            8'h72:   begin key_hit = 1'b1; key_idx = 2'd1; end
            8'h6B:   begin key_hit = 1'b1; key_idx = 2'd2; end
            8'h74:   begin key_hit = 1'b1; key_idx = 2'd3; end
            default: ;
          endcase
        end else begin
          case (data_in)
            8'h29:   pause_d = pause_q ^ ~brk_q;
            8'h76:   esc_d = ~brk_q;
`ifdef PS2_WASD_EN
            8'h1D:   begin key_hit = 1'b1; key_wasd = 1'b1; key_idx = 2'd0; end
            8'h1B:   begin key_hit = 1'b1; key_wasd = 1'b1; key_idx = 2'd1; end
            8'h1C:   begin key_hit = 1'b1; key_wasd = 1'b1; key_idx = 2'd2; end
            8'h23:   begin key_hit = 1'b1; key_wasd = 1'b1; key_idx = 2'd3; end
`endif
            default: ;
          endcase
        end
      end
    end else if (ext_q || brk_q) begin
      // A prefix left dangling too long is dropped so it cannot taint a later key.
      if (cnt_q == CntLast) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (key_hit) begin
`ifdef PS2_WASD_EN
      if (key_wasd) wasd_d[key_idx] = ~brk_q;
      else          arrow_d[key_idx] = ~brk_q;
`else
      arrow_d[key_idx] = ~brk_q;
`endif
    end

`ifdef PS2_WASD_EN
    held_d = arrow_d | wasd_d;
`else
    held_d = arrow_d;
`endif

    if (key_hit) begin
      if (!brk_q) begin
        // Typematic repeats of an already held key must not steal the direction.
        if (!key_held[key_idx]) dir_d = key_idx;
      end else if (dir_q == key_idx && !held_d[key_idx] && held_d != 4'b0000) begin
        dir_d = first_held(held_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      cnt_q   <= '0;
      arrow_q <= 4'b0000;
      dir_q   <= 2'd0;
      pause_q <= 1'b0;
      esc_q   <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      cnt_q   <= cnt_d;
      arrow_q <= arrow_d;
      dir_q   <= dir_d;
      pause_q <= pause_d;
      esc_q   <= esc_d;
    end
  end

`ifdef PS2_WASD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wasd_q <= 4'b0000;
    else      wasd_q <= wasd_d;
  end

  assign key_held = arrow_q | wasd_q;
`else
  assign key_held = arrow_q;
`endif

  assign dir       = dir_q;
  assign dir_valid = |key_held;
  assign pause     = pause_q;
  assign esc_pulse = esc_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Scoreboard bench for ps2_key_controller: a driver feeds scancodes through the valid/ack
// handshake and queues expected state; a monitor compares one cycle after each ack.
module tb_ps2_key_controller;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       ack;
  logic [3:0] key_held;
  logic [1:0] dir;
  logic       dir_valid;
  logic       pause;
  logic       esc_pulse;

  ps2_key_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ack        (ack),
    .key_held   (key_held),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .pause      (pause),
    .esc_pulse  (esc_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] held;
    logic [1:0] dir;
    logic       dv;
    logic       pause;
    logic       esc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_acks = 0;
  int   n_bytes = 0;

  // Reference model: keyboard state as the decoder should understand it.
  bit       m_ext, m_brk, m_pause;
  bit [3:0] m_arrow, m_wasd;
  int       m_dir;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pause = 0;
    m_arrow = 4'b0000; m_wasd = 4'b0000; m_dir = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output exp_t e);
    int       k;
    bit       wasd_key;
    bit       esc;
    bit [3:0] held;
    k = -1; wasd_key = 0; esc = 0;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_ext) begin
        case (b)
          8'h75: k = 0;
          8'h72: k = 1;
          8'h6B: k = 2;
          8'h74: k = 3;
          default: ;
        endcase
      end else begin
        if (b == 8'h29 && !m_brk) m_pause = !m_pause;
        if (b == 8'h76 && !m_brk) esc = 1;
`ifdef PS2_WASD_EN
        case (b)
          8'h1D: k = 0;
          8'h1B: k = 1;
          8'h1C: k = 2;
          8'h23: k = 3;
          default: ;
        endcase
        wasd_key = (k >= 0);
`endif
      end
      if (k >= 0) begin
        held = m_arrow | m_wasd;
        if (!m_brk) begin
          if (!held[k]) m_dir = k;
          if (wasd_key) m_wasd[k] = 1; else m_arrow[k] = 1;
        end else begin
          if (wasd_key) m_wasd[k] = 0; else m_arrow[k] = 0;
          held = m_arrow | m_wasd;
          if (m_dir == k && !held[k] && held != 0)
            for (int i = 3; i >= 0; i--) if (held[i]) m_dir = i;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
    held    = m_arrow | m_wasd;
    e.held  = held;
    e.dir   = 2'(m_dir);
    e.dv    = |held;
    e.pause = m_pause;
    e.esc   = esc;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // gap: idle negedges (beyond the minimum two) before raising data_valid.
  task automatic send(input logic [7:0] b, input int hold, input int gap);
    exp_t e;
    int   n;
    if (gap >= int'(TO)) begin
      m_ext = 0;
      m_brk = 0;
    end
    repeat (gap + 2) @(negedge clk);
    model_byte(b, e);
    exp_q.push_back(e);
    data_in    = b;
    data_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    if (!ack) begin
      chk("ack_timeout", 0, 1);
      void'(exp_q.pop_back());
    end
    repeat (hold) @(negedge clk);
    data_valid = 1'b0;
    n_bytes++;
  endtask

  function automatic logic [7:0] arrow_code(input int i);
    logic [7:0] c;
    case (i)
      0:       c = 8'h75;
      1:       c = 8'h72;
      2:       c = 8'h6B;
      default: c = 8'h74;
    endcase
    return c;
  endfunction

  task automatic random_event();
    int         r, h, g;
    logic [7:0] c;
    r = $urandom_range(0, 99);
    h = $urandom_range(0, 3);
    g = $urandom_range(0, 4);
    c = arrow_code($urandom_range(0, 3));
    if (r < 35) begin
      send(8'hE0, h, g);
      send(c, $urandom_range(0, 3), $urandom_range(0, 4));
    end else if (r < 65) begin
      send(8'hE0, h, g);
      send(8'hF0, $urandom_range(0, 3), $urandom_range(0, 4));
      send(c, $urandom_range(0, 3), $urandom_range(0, 4));
    end else if (r < 73) begin
      send(8'h29, h, g);
    end else if (r < 78) begin
      send(8'hF0, h, g);
      send(8'h29, h, g);
    end else if (r < 84) begin
      send(8'h76, h, g);
    end else if (r < 92) begin
      send(8'($urandom_range(0, 255)), h, g);
    end else begin
      send(r[0] ? 8'hE0 : 8'hF0, h, g);
      send(c, h, int'(TO) + 9);
    end
  endtask

  // Monitor: one cycle after each ack the decoded state must match the queue head.
  initial begin
    bit   cmp_next;
    bit   esc_next;
    exp_t e;
    cmp_next = 0;
    esc_next = 0;
    forever begin
      @(negedge clk);
      if (esc_next) begin
        chk("esc_width", esc_pulse, 0);
        esc_next = 0;
      end
      if (cmp_next) begin
        cmp_next = 0;
        chk("ack_width", ack, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("key_held", key_held, e.held);
          chk("dir", dir, e.dir);
          chk("dir_valid", dir_valid, e.dv);
          chk("pause", pause, e.pause);
          chk("esc_pulse", esc_pulse, e.esc);
          esc_next = 1;
        end
      end
      if (ack && rst) begin
        n_acks++;
        cmp_next = 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_dir", dir, 0);
    chk("rst_dir_valid", dir_valid, 0);
    chk("rst_pause", pause, 0);
    chk("rst_esc", esc_pulse, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single press, then left on top of up, then release left.
    send(8'hE0, 1, 0);
    send(8'h75, 1, 0);
    send(8'hE0, 0, 1);
    send(8'h6B, 2, 0);
    send(8'hE0, 0, 0);
    send(8'hF0, 1, 2);
    send(8'h6B, 3, 0);
    // Repeat make of a held key, then release everything.
    send(8'hE0, 0, 0);
    send(8'h75, 0, 0);
    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h75, 0, 0);

    // Dangling prefix expires; 75 then decodes as a plain, ignored code.
    send(8'hE0, 1, 0);
    send(8'h75, 1, int'(TO) + 4);

    // Pause toggles on make only.
    send(8'h29, 0, 0);
    send(8'hF0, 1, 0);
    send(8'h29, 1, 0);
    send(8'h29, 2, 1);

    // Esc, with valid held long after the ack.
    send(8'h76, 10, 0);

    repeat (250) random_event();

    // Reset between E0 and F0 discards the prefix.
    send(8'hE0, 1, 0);
    send(8'h72, 1, 0);
    send(8'h29, 1, 0);
    send(8'hE0, 1, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_key_held", key_held, 0);
    chk("mid_rst_dir", dir, 0);
    chk("mid_rst_dir_valid", dir_valid, 0);
    chk("mid_rst_pause", pause, 0);
    chk("mid_rst_esc", esc_pulse, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    send(8'hF0, 1, 1);
    send(8'h75, 1, 0);
`ifdef PS2_WASD_EN
    send(8'h1D, 1, 0);
`endif

    repeat (6) @(negedge clk);
    chk("ack_count", n_acks, n_bytes);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
